multi_timer: RTL and testbench

Parametrised bank of independent, trigger-started down-counters. Each channel holds a programmable reload value, starts on a rising edge of its trigger, counts down on enabled cycles and emits a one-cycle terminal pulse. Channels run in one-shot or auto-reload mode. The block replaces the single-channel loadable down-counter, and load and count paths are separate ports rather than a shared bidirectional bus.

---
 rtl/multi_timer_pkg.sv | 23 ++
 rtl/timer_channel.sv | 104 ++++++++++
 rtl/multi_timer.sv | 54 +++++
 tb/tb_multi_timer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel down-counter timer.
//   MODE_ONESHOT / MODE_AUTO : per-channel mode encodings
//   t_tmr_state              : channel state (IDLE, RUN)
//   cw_of()                  : channel-select width for a given channel count
package multi_timer_pkg;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_AUTO    = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } t_tmr_state;

  // Select width is $clog2(CH) but never narrower than one bit.
  function automatic int unsigned cw_of(input int unsigned ch);
    if (ch <= 32'd2) begin
      return 32'd1;
    end
    return $clog2(ch);
  endfunction

endpackage : multi_timer_pkg

// File: rtl/timer_channel.sv
// One timer channel: reload register, trigger edge detect, down-counter,
// IDLE/RUN state and registered terminal pulse.
//   clk, rst  : clock, synchronous active-high reset
//   i_we      : write i_val into this channel's reload register
//   i_val     : reload value being written
//   i_trig    : start input, rising edge (re)starts the channel
//   i_en      : count enable
//   i_mode    : 0 = one-shot, 1 = auto-reload (sampled at terminal count)
//   o_cnt     : current counter value
//   o_busy    : channel is in RUN
//   o_pulse   : one-cycle pulse in the cycle after the counter leaves 1
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_we,
  input  logic [N-1:0] i_val,
  input  logic         i_trig,
  input  logic         i_en,
  input  logic         i_mode,
  output logic [N-1:0] o_cnt,
  output logic         o_busy,
  output logic         o_pulse
);

  t_tmr_state   r_state;
  t_tmr_state   w_state_nxt;
  logic [N-1:0] r_cnt;
  logic [N-1:0] w_cnt_nxt;
  logic [N-1:0] r_reload;
  logic [N-1:0] w_rl;
  logic         r_trig;
  logic         r_pulse;
  logic         w_edge;
  logic         w_term;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_reload <= '0;
      r_trig   <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_reload <= w_rl;
      r_trig   <= i_trig;
      r_pulse  <= w_term;
    end
  end

  // Next-state logic; a same-cycle write bypasses the reload register
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rl        = i_we ? i_val : r_reload;
    w_edge      = i_trig & ~r_trig;
    w_term      = (r_state == RUN) & i_en & (r_cnt == N'(1)) & ~w_edge;

    if (w_edge) begin
      // Retrigger wins over everything, including a terminal count
      if (w_rl != '0) begin
        w_cnt_nxt   = w_rl;
        w_state_nxt = RUN;
      end else begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        RUN: begin
          if (w_term) begin
            if ((i_mode == MODE_AUTO) && (w_rl != '0)) begin
              w_cnt_nxt   = w_rl;
              w_state_nxt = RUN;
            end else begin
              w_cnt_nxt   = '0;
              w_state_nxt = IDLE;
            end
          end else if (i_en && (r_cnt > N'(1))) begin
            w_cnt_nxt = r_cnt - N'(1);
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign o_cnt   = r_cnt;
  assign o_busy  = (r_state == RUN);
  assign o_pulse = r_pulse;

endmodule : timer_channel

// File: rtl/multi_timer.sv
// Bank of CH independent trigger-started down-counters.
//   clk, rst   : clock, synchronous active-high reset
//   load_we    : write load_val into the reload register of channel load_ch
//   load_ch    : write target; values >= CH are ignored
//   load_val   : reload value
//   trig       : per-channel start (rising edge)
//   en         : per-channel count enable
//   mode       : per-channel mode, 0 = one-shot, 1 = auto-reload
//   count      : packed counters, channel i at count[i*N +: N]
//   busy       : per-channel RUN indication
//   out_pulse  : per-channel one-cycle terminal pulse
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned CH = 4,
  localparam int unsigned CW = cw_of(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_we,
  input  logic [CW-1:0]   load_ch,
  input  logic [N-1:0]    load_val,
  input  logic [CH-1:0]   trig,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   mode,
  output logic [CH*N-1:0] count,
  output logic [CH-1:0]   busy,
  output logic [CH-1:0]   out_pulse
);

  logic [CH-1:0] w_we;

  // Write decode: an out-of-range load_ch matches no channel
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign w_we[i] = load_we & (load_ch == CW'(i));

    timer_channel #(
      .N(N)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we[i]),
      .i_val   (load_val),
      .i_trig  (trig[i]),
      .i_en    (en[i]),
      .i_mode  (mode[i]),
      .o_cnt   (count[i*N +: N]),
      .o_busy  (busy[i]),
      .o_pulse (out_pulse[i])
    );
  end

endmodule : multi_timer

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: a vector table of per-cycle inputs and
// expected outputs, driven on the falling edge and checked through a
// scoreboard just after the following rising edge.
module tb_multi_timer;

  localparam int unsigned N  = 8;
  localparam int unsigned CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_we;
  logic [1:0]    load_ch;
  logic [7:0]    load_val;
  logic [3:0]    trig, en, mode;
  logic [31:0]   count;
  logic [3:0]    busy, out_pulse;

  // Second instance with CH = 3 for the out-of-range write check
  logic          ld3_we;
  logic [1:0]    ld3_ch;
  logic [7:0]    ld3_val;
  logic [2:0]    trig3, en3, mode3;
  logic [23:0]   count3;
  logic [2:0]    busy3, pulse3;

  always #5 clk = ~clk;

  multi_timer #(.N(N), .CH(CH)) u_dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_ch(load_ch),
    .load_val(load_val), .trig(trig), .en(en), .mode(mode),
    .count(count), .busy(busy), .out_pulse(out_pulse)
  );

  multi_timer #(.N(N), .CH(3)) u_dut3 (
    .clk(clk), .rst(rst), .load_we(ld3_we), .load_ch(ld3_ch),
    .load_val(ld3_val), .trig(trig3), .en(en3), .mode(mode3),
    .count(count3), .busy(busy3), .out_pulse(pulse3)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  ch;
    logic [7:0]  val;
    logic [3:0]  trig;
    logic [3:0]  en;
    logic [3:0]  mode;
    logic [31:0] ex_cnt;
    logic [3:0]  ex_busy;
    logic [3:0]  ex_pulse;
  } vec_t;

  typedef struct {
    int          tag;
    bit          on3;
    logic [31:0] ex_cnt;
    logic [3:0]  ex_busy;
    logic [3:0]  ex_pulse;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Inputs for the next table row
  logic       cur_rst, cur_we;
  logic [1:0] cur_ch;
  logic [7:0] cur_val;
  logic [3:0] cur_trig, cur_en, cur_mode;

  function automatic logic [31:0] c4(input int unsigned ch, input logic [7:0] val);
    return 32'(val) << (8 * ch);
  endfunction

  // Append one row; a write request lasts exactly one row
  task automatic v(input logic [31:0] c, input logic [3:0] b, input logic [3:0] p);
    vec_t x;
    x.rst = cur_rst; x.we = cur_we; x.ch = cur_ch; x.val = cur_val;
    x.trig = cur_trig; x.en = cur_en; x.mode = cur_mode;
    x.ex_cnt = c; x.ex_busy = b; x.ex_pulse = p;
    vecs.push_back(x);
    cur_we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] val);
    cur_we = 1'b1; cur_ch = ch; cur_val = val;
  endtask

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row%0d got %h want %h", nm, tag, act, exp);
    end
  endtask

  // Scoreboard consumer: compare just after each rising edge
  exp_t e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.on3) begin
          chk("count3",    e.tag, {8'h0, count3}, e.ex_cnt);
          chk("busy3",     e.tag, {28'h0, 1'b0, busy3}, {28'h0, e.ex_busy});
          chk("out_pulse3",e.tag, {28'h0, 1'b0, pulse3}, {28'h0, e.ex_pulse});
        end else begin
          chk("count",     e.tag, count, e.ex_cnt);
          chk("busy",      e.tag, {28'h0, busy}, {28'h0, e.ex_busy});
          chk("out_pulse", e.tag, {28'h0, out_pulse}, {28'h0, e.ex_pulse});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push3(input int tag, input logic [23:0] c, input logic [2:0] b, input logic [2:0] p);
    sb.push_back('{tag: tag, on3: 1'b1, ex_cnt: {8'h0, c}, ex_busy: {1'b0, b}, ex_pulse: {1'b0, p}});
  endtask

  initial begin
    rst = 1'b1; load_we = 1'b0; load_ch = '0; load_val = '0;
    trig = '0; en = '0; mode = '0;
    ld3_we = 1'b0; ld3_ch = '0; ld3_val = '0; trig3 = '0; en3 = '0; mode3 = '0;
    cur_rst = 1'b1; cur_we = 1'b0; cur_ch = '0; cur_val = '0;
    cur_trig = '0; cur_en = '0; cur_mode = '0;

    // Reset
    v(0, 4'h0, 4'h0);
    v(0, 4'h0, 4'h0);
    cur_rst = 1'b0;

    // One-shot ch0, reload 5
    cur_en = 4'hF; cur_mode = 4'h0;
    wr(2'd0, 8'd5);                   v(0, 4'h0, 4'h0);
    cur_trig = 4'h1;                  v(c4(0, 8'd5), 4'h1, 4'h0);
    cur_trig = 4'h0;
    for (int k = 4; k >= 1; k--)      v(c4(0, 8'(k)), 4'h1, 4'h0);
    v(0, 4'h0, 4'h1);
    v(0, 4'h0, 4'h0);

    // Auto-reload ch1, reload 3, then stop via mode change
    wr(2'd1, 8'd3); cur_mode = 4'h2; v(0, 4'h0, 4'h0);
    cur_trig = 4'h2;                  v(c4(1, 8'd3), 4'h2, 4'h0);
    cur_trig = 4'h0;
    for (int r = 0; r < 2; r++) begin
      v(c4(1, 8'd2), 4'h2, 4'h0);
      v(c4(1, 8'd1), 4'h2, 4'h0);
      v(c4(1, 8'd3), 4'h2, 4'h2);
    end
    v(c4(1, 8'd2), 4'h2, 4'h0);
    v(c4(1, 8'd1), 4'h2, 4'h0);
    cur_mode = 4'h0;                  v(0, 4'h0, 4'h2);
    v(0, 4'h0, 4'h0);

    // Enable gating and retrigger on ch2, reload 4
    wr(2'd2, 8'd4);                   v(0, 4'h0, 4'h0);
    cur_trig = 4'h4;                  v(c4(2, 8'd4), 4'h4, 4'h0);
    cur_trig = 4'h0;
    v(c4(2, 8'd3), 4'h4, 4'h0);
    v(c4(2, 8'd2), 4'h4, 4'h0);
    cur_en = 4'hB;
    for (int k = 0; k < 3; k++)       v(c4(2, 8'd2), 4'h4, 4'h0);
    cur_en = 4'hF;                    v(c4(2, 8'd1), 4'h4, 4'h0);
    cur_trig = 4'h4;                  v(c4(2, 8'd4), 4'h4, 4'h0);
    cur_trig = 4'h0;
    v(c4(2, 8'd3), 4'h4, 4'h0);
    v(c4(2, 8'd2), 4'h4, 4'h0);
    v(c4(2, 8'd1), 4'h4, 4'h0);
    v(0, 4'h0, 4'h4);
    v(0, 4'h0, 4'h0);

    // Reload 0 and reload 1 on ch3
    cur_trig = 4'h8;                  v(0, 4'h0, 4'h0);
    cur_trig = 4'h0;                  v(0, 4'h0, 4'h0);
    wr(2'd3, 8'd1);                   v(0, 4'h0, 4'h0);
    cur_trig = 4'h8;                  v(c4(3, 8'd1), 4'h8, 4'h0);
    cur_trig = 4'h0;                  v(0, 4'h0, 4'h8);
    v(0, 4'h0, 4'h0);

    // Same-cycle write + trigger on ch3, then reset with two channels running
    wr(2'd3, 8'd7); cur_trig = 4'h8;  v(c4(3, 8'd7), 4'h8, 4'h0);
    cur_trig = 4'h1;                  v(c4(3, 8'd6) | c4(0, 8'd5), 4'h9, 4'h0);
    cur_trig = 4'h0;                  v(c4(3, 8'd5) | c4(0, 8'd4), 4'h9, 4'h0);
    cur_rst = 1'b1; cur_trig = 4'h8;  v(0, 4'h0, 4'h0);
    cur_rst = 1'b0; wr(2'd3, 8'd2);   v(c4(3, 8'd2), 4'h8, 4'h0);
    v(c4(3, 8'd1), 4'h8, 4'h0);
    v(0, 4'h0, 4'h8);
    cur_trig = 4'h0;                  v(0, 4'h0, 4'h0);
    // Reset cleared the ch0 reload, so a trigger leaves it idle
    cur_trig = 4'h1;                  v(0, 4'h0, 4'h0);
    cur_trig = 4'h0;                  v(0, 4'h0, 4'h0);

    // Full-scale reload on ch0
    wr(2'd0, 8'd255);                 v(0, 4'h0, 4'h0);
    cur_trig = 4'h1;                  v(c4(0, 8'd255), 4'h1, 4'h0);
    cur_trig = 4'h0;
    for (int k = 254; k >= 1; k--)    v(c4(0, 8'(k)), 4'h1, 4'h0);
    v(0, 4'h0, 4'h1);
    v(0, 4'h0, 4'h0);

    // Apply the table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; load_we = vecs[i].we; load_ch = vecs[i].ch;
      load_val = vecs[i].val; trig = vecs[i].trig; en = vecs[i].en;
      mode = vecs[i].mode;
      sb.push_back('{tag: i, on3: 1'b0, ex_cnt: vecs[i].ex_cnt,
                     ex_busy: vecs[i].ex_busy, ex_pulse: vecs[i].ex_pulse});
    end

    // CH = 3 instance: a write to load_ch = 3 must not touch any channel
    @(negedge clk);
    load_we = 1'b0; trig = '0;
    ld3_we = 1'b1; ld3_ch = 2'd0; ld3_val = 8'd2; en3 = 3'b111;
    push3(1000, 24'h0, 3'b000, 3'b000);
    @(negedge clk);
    ld3_ch = 2'd3; ld3_val = 8'd9;
    push3(1001, 24'h0, 3'b000, 3'b000);
    @(negedge clk);
    ld3_we = 1'b0; trig3 = 3'b111;
    push3(1002, 24'h000002, 3'b001, 3'b000);
    @(negedge clk);
    trig3 = 3'b000;
    push3(1003, 24'h000001, 3'b001, 3'b000);
    @(negedge clk);
    push3(1004, 24'h000000, 3'b000, 3'b001);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_multi_timer
